// File: rtl/feeder_pkg.sv
// feeder_pkg: shared FSM state type and instruction constants for instruction_feeder.
package feeder_pkg;
   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 16'hFFFF;
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
endpackage

// File: rtl/feeder_mem.sv
// feeder_mem: DEPTH x 16 program store, synchronous write, synchronous write-first read.
module feeder_mem
   import feeder_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic               clock,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [INSTR_W-1:0] rdata_o
);
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] rdata_q;
   // Write-first bypass lets a fetch launched on the same edge see the new word.
   always_ff @(posedge clock) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/instruction_feeder.sv
// instruction_feeder: program store + PC feeding 16-bit words to the processor iin port.
// Define FEEDER_TIMEOUT_EN to build the done-timeout counter that drives error.
module instruction_feeder
   import feeder_pkg::*;
#(
   parameter int                 DEPTH     = 16,
   parameter int                 ADDR_W    = 4,
   parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD,
   parameter int                 TIMEOUT   = 64
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic               done,
   output logic [INSTR_W-1:0] iin,
   output logic               iin_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic               error
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] iin_q, iin_d, word;
   logic valid_q, valid_d, busy_q, halted_q, error_q, error_d, idle_like;
   assign idle_like = state_q == IDLE || state_q == HALT;
   // Read address follows next-state pc so the word is ready during FETCH.
   feeder_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clock   (clock),
      .we_i    (load_en && idle_like),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i (pc_d),
      .rdata_o (word)
   );
`ifdef FEEDER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`endif
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iin_d   = iin_q;
      valid_d = valid_q;
      error_d = error_q;
`ifdef FEEDER_TIMEOUT_EN
      cnt_d = (state_q == ISSUE && !done) ? cnt_q + 1'b1 : '0;
`endif
      case (state_q)
         IDLE, HALT: if (start) begin
            pc_d    = '0;
            error_d = 1'b0;
            state_d = FETCH;
         end
         FETCH: if (word == HALT_WORD) state_d = HALT;
         else begin
            iin_d   = word;
            valid_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: if (done) begin
            valid_d = 1'b0;
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
         end
`ifdef FEEDER_TIMEOUT_EN
         else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            valid_d = 1'b0;
            state_d = HALT;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         iin_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         iin_q    <= iin_d;
         valid_q  <= valid_d;
         busy_q   <= state_d == FETCH || state_d == ISSUE;
         halted_q <= state_d == HALT;
         error_q  <= error_d;
      end
   end
   assign iin       = iin_q;
   assign iin_valid = valid_q;
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign error     = error_q;
endmodule

// File: doc/instruction_feeder.md
Name: instruction_feeder

Overview:
Supplies 16-bit instruction words to the processor's iin input, one at a time. It holds a small loadable program store and a program counter. Each word is presented stable until the processor pulses done, then the next word is fetched. It is the producer end of the iin interface; the processor is the consumer.

Parameters:
DEPTH, 16, number of instruction words in the program store (power of two)
ADDR_W, 4, program counter / load address width, equals log2(DEPTH)
HALT_WORD, 16'hFFFF, sentinel instruction that ends execution; it is never issued
TIMEOUT, 64, cycles to wait for done before flagging an error (used only with the optional feature)

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
load_en  input  1  write strobe for the program store
load_addr  input  ADDR_W  write address
load_data  input  16  write data
start  input  1  one-cycle pulse; begins execution from address 0
done  input  1  processor has finished the current instruction
iin  output  16  instruction word to the processor
iin_valid  output  1  iin holds a live instruction
pc  output  ADDR_W  address of the current or next word
busy  output  1  high in FETCH or ISSUE
halted  output  1  high in HALT
error  output  1  timeout flag (optional feature)

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; pc=0; iin=16'h0000; iin_valid=0; busy=0; halted=0; error=0.
  - Program store contents are not reset; they are preserved.
- States: IDLE, FETCH, ISSUE, HALT. The state and all outputs are registered.
- Loading:
  - load_en=1 in IDLE or HALT writes mem[load_addr]=load_data at the clock edge.
  - load_en in FETCH or ISSUE is ignored; memory is unchanged.
- IDLE or HALT, start=1:
  - pc<=0, halted<=0, error<=0, next state FETCH.
  - If load_en and start occur in the same cycle, the write completes and the fetch sees the new data. This matters when load_addr=0.
- FETCH: one cycle with a synchronous read of mem[pc].
  - Word==HALT_WORD: go to HALT; iin_valid stays 0.
  - Otherwise: iin<=word, iin_valid<=1, go to ISSUE.
- ISSUE: iin and iin_valid are held stable until done=1.
  - On done=1: iin_valid<=0, pc<=pc+1 modulo DEPTH, go to FETCH.
  - Wrap-around: from DEPTH-1, pc returns to 0 and execution continues.
- done is sampled only in ISSUE; it is ignored in every other state.
  - If done is held high, each ISSUE visit consumes one cycle of it. A word therefore issues for a minimum of 1 cycle.
- start is ignored while busy.
- Latency:
  - start at edge N -> FETCH during cycle N+1 -> iin_valid=1 after edge N+2.
  - done at edge M -> next iin_valid after edge M+2.
- HALT: halted=1, iin retains its last value, iin_valid=0, pc points at the halt word.
- Reset asserted mid-FETCH or mid-ISSUE forces IDLE immediately; there is no partial issue.

Optional Feature:
FEEDER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle with done=0.
  - On reaching TIMEOUT-1 without done: error<=1, iin_valid<=0, go to HALT.
  - error stays set until reset or the next accepted start.
- Undefined: no counter is built; error is tied to 0; ISSUE waits indefinitely.

Decomposition:
- Shared package (feeder_pkg):
  - state enum {IDLE, FETCH, ISSUE, HALT}
  - default HALT_WORD constant
  - instruction width constant (16)
- One natural sub-module: feeder_mem, a DEPTH x 16 store with synchronous write and synchronous read. The top level holds the FSM, pc, output registers and the optional timeout counter.

Test Plan:
- Load mem[0..2]=16'h1234,16'h5678,16'h9ABC and mem[3]=16'hFFFF; pulse start; pulse done 3 cycles after each iin_valid.
  - Expect iin sequence 1234, 5678, 9ABC, each valid 2 cycles after start/done.
  - Then halted=1, pc=3, iin_valid=0.
- During ISSUE, hold done=0 for 20 cycles.
  - Expect iin stable and iin_valid=1 throughout; load_en writes in this window do not alter memory (read back after HALT).
- Fill all 16 words with 16'h0001 and pulse done continuously.
  - Expect pc to wrap 15->0 with no halt; busy stays 1.
- Drop resetn mid-ISSUE at pc=2.
  - Expect immediate state IDLE, pc=0, iin=0, iin_valid=0.
  - After restart, memory is intact and 16'h1234 issues first.
- Pulse start while busy, and pulse done in IDLE.
  - Expect no effect: pc and state unchanged.
- With FEEDER_TIMEOUT_EN and TIMEOUT=8, withhold done.
  - Expect error=1 and halted=1 after 8 ISSUE cycles; the next start clears error.
